// File: rtl/spi_pkg.sv
// Shared types for the SPI frame receiver.
// FSM states, SPI mode encodings and counter sizing.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_e;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Bits needed for a counter running 0..n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// Pin and frame bundle of the SPI frame receiver.
// master: receiver side; slave: sensor and frame consumer side.
interface spi_frame_rx_if #(
    parameter int FRAME_BITS = 40
);
    logic                  start;
    logic                  cont;
    logic                  miso;
    logic                  sclk;
    logic                  ss_n;
    logic [FRAME_BITS-1:0] dout;
    logic                  dout_valid;
    logic                  busy;

    modport master (
        input  start, cont, miso,
        output sclk, ss_n, dout, dout_valid, busy
    );

    modport slave (
        output start, cont, miso,
        input  sclk, ss_n, dout, dout_valid, busy
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, registered sclk,
// leading/trailing edge strobes in the cycle before sclk toggles.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 50,
    parameter bit IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic lead,
    output logic trail
);
    localparam int HW = cnt_w(CLK_DIV);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] hcnt_q;
    logic          sclk_q;
    logic          tick;

    assign tick  = en && (hcnt_q == HALF_LAST);
    assign lead  = tick && (sclk_q == IDLE_LVL);
    assign trail = tick && (sclk_q != IDLE_LVL);
    assign sclk  = sclk_q;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            hcnt_q <= '0;
            sclk_q <= IDLE_LVL;
        end else if (tick) begin
            hcnt_q <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            hcnt_q <= hcnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/spi_frame_rx.sv
// SPI master receiver: clocks in one MSB-first frame per transfer
// and publishes it on dout with a single-cycle valid strobe.
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = 40,
    parameter int CLK_DIV    = 50,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter int GAP_CYCLES = 100
) (
    input logic            clk,
    input logic            rst,
    spi_frame_rx_if.master bus
);
    localparam int CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = cnt_w(CMAX);
    localparam int BW   = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);
    localparam logic [1:0]    MODE     = {CPOL, CPHA};
    localparam bit IDLE_LVL = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
    localparam bit ON_TRAIL = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);

    spi_state_e            state_q, state_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [FRAME_BITS-1:0] dout_q, dout_d;
    logic                  ss_n_q, ss_n_d;
    logic                  valid_q, valid_d;
    logic                  lead, trail, sample;

    spi_sclk_gen #(
        .CLK_DIV  (CLK_DIV),
        .IDLE_LVL (IDLE_LVL)
    ) u_sclk (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == XFER),
        .sclk  (bus.sclk),
        .lead  (lead),
        .trail (trail)
    );

    assign sample = ON_TRAIL ? trail : lead;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        ss_n_d  = ss_n_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                ss_n_d = 1'b1;
                if (bus.start || bus.cont) begin
                    state_d = SETUP;
                    ss_n_d  = 1'b0;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (cyc_q == DIV_LAST) begin
                    state_d = XFER;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            XFER: begin
                if (sample) begin
                    sh_d  = (sh_q << 1) | FRAME_BITS'(bus.miso);
                    bit_d = bit_q + 1'b1;
                end
                // The final edge is always a trailing one.
                if (trail && (bit_d == BIT_LAST)) begin
                    state_d = HOLD;
                    cyc_d   = '0;
                end
            end
            HOLD: begin
                if (cyc_q == DIV_LAST) begin
                    state_d = GAP;
                    cyc_d   = '0;
                    ss_n_d  = 1'b1;
                    dout_d  = sh_q;
                    valid_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            GAP: begin
                if (cyc_q == GAP_LAST) begin
                    cyc_d = '0;
                    if (bus.cont) begin
                        state_d = SETUP;
                        ss_n_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            ss_n_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            ss_n_q  <= ss_n_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ss_n       = ss_n_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: 40-bit, 8-bit x four modes,
// and 1-bit minimum-divider instances with behavioural SPI slaves.
module tb_spi_frame_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst40 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 40-bit instance, mode 0
    logic        start40 = 1'b0;
    logic [39:0] data40 = '0;
    logic [39:0] sh40 = '0;
    logic        p40;
    spi_frame_rx_if #(.FRAME_BITS(40)) bus40 ();
    assign bus40.start = start40;
    assign bus40.cont  = 1'b0;
    assign bus40.miso  = sh40[39];
    spi_frame_rx #(
        .FRAME_BITS(40), .CLK_DIV(4), .CPOL(1'b0),
        .CPHA(1'b0), .GAP_CYCLES(6)
    ) u_dut40 (.clk(clk), .rst(rst40), .bus(bus40));

    always @(posedge clk) begin
        p40 <= bus40.sclk;
        if (bus40.ss_n) sh40 <= data40;
        else if (p40 && !bus40.sclk) sh40 <= sh40 << 1;
    end

    // 1-bit instance, minimum divider
    logic start1 = 1'b0;
    logic data1 = 1'b0;
    logic sh1 = 1'b0;
    logic p1;
    spi_frame_rx_if #(.FRAME_BITS(1)) bus1 ();
    assign bus1.start = start1;
    assign bus1.cont  = 1'b0;
    assign bus1.miso  = sh1;
    spi_frame_rx #(
        .FRAME_BITS(1), .CLK_DIV(2), .CPOL(1'b0),
        .CPHA(1'b0), .GAP_CYCLES(2)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always @(posedge clk) begin
        p1 <= bus1.sclk;
        if (bus1.ss_n) sh1 <= data1;
        else if (p1 && !bus1.sclk) sh1 <= 1'b0;
    end

    // 8-bit instances, one per mode (index = {CPOL,CPHA})
    logic       start8 [4];
    logic       cont8  [4];
    logic [7:0] data8  [4];
    wire  [7:0] dout8  [4];
    wire        sclk8  [4];
    wire        ss8    [4];
    wire        valid8 [4];
    wire        busy8  [4];
    wire [31:0] edges8 [4];

    for (genvar i = 0; i < 4; i++) begin : g8
        localparam bit PL = (i / 2) != 0;
        localparam bit PH = (i % 2) != 0;
        spi_frame_rx_if #(.FRAME_BITS(8)) bus ();
        logic [7:0] sh = '0;
        logic       mr = 1'b0;
        logic       prv;
        int         ecnt = 0;

        spi_frame_rx #(
            .FRAME_BITS(8), .CLK_DIV(4), .CPOL(PL),
            .CPHA(PH), .GAP_CYCLES(5)
        ) u_dut (.clk(clk), .rst(rst), .bus(bus));

        assign bus.start = start8[i];
        assign bus.cont  = cont8[i];
        assign bus.miso  = PH ? mr : sh[7];
        assign dout8[i]  = bus.dout;
        assign sclk8[i]  = bus.sclk;
        assign ss8[i]    = bus.ss_n;
        assign valid8[i] = bus.dout_valid;
        assign busy8[i]  = bus.busy;
        assign edges8[i] = ecnt;

        always @(posedge clk) begin
            prv <= bus.sclk;
            if (bus.sclk != prv) ecnt <= ecnt + 1;
            if (bus.ss_n) begin
                sh <= data8[i];
            end else if (bus.sclk != prv) begin
                if (PH && bus.sclk != PL) begin
                    mr <= sh[7];
                    sh <= sh << 1;
                end else if (!PH && bus.sclk == PL) begin
                    sh <= sh << 1;
                end
            end
        end
    end

    task automatic frame40(input logic [39:0] d, input int pa,
                           input int pb, output int vcyc,
                           output int vcnt, output int low,
                           output int nbusy, output int bad);
        logic [39:0] prev;
        vcyc = 0; vcnt = 0; low = 0; nbusy = 0; bad = 0;
        data40 = d;
        prev = bus40.dout;
        start40 = 1'b1;
        for (int c = 1; c <= 345; c++) begin
            tick();
            start40 = (c == pa) || (c == pb);
            if (!bus40.ss_n) low++;
            if (c < 329 && !bus40.busy) nbusy++;
            if (bus40.dout_valid) begin
                vcnt++;
                vcyc = c;
            end else if (bus40.dout !== prev) begin
                bad++;
            end
            prev = bus40.dout;
        end
    endtask

    initial begin
        int vcyc, vcnt, low, nbusy, bad, lat, nv, hi, ng;
        logic [7:0] got [4];
        int gaps [2];

        for (int m = 0; m < 4; m++) begin
            start8[m] = 1'b0;
            cont8[m]  = 1'b0;
            data8[m]  = 8'h00;
        end
        tick();
        tick();
        rst = 1'b0;
        rst40 = 1'b0;
        tick();

        // reset state
        check("rst_ss_n", bus40.ss_n, 1);
        check("rst_sclk", bus40.sclk, 0);
        check("rst_dout", bus40.dout, 0);
        check("rst_valid", bus40.dout_valid, 0);
        check("rst_busy", bus40.busy, 0);
        check("rst_sclk_m3", sclk8[3], 1);

        // 40-bit mode-0 frame
        frame40(40'hA5_C3_0F_F0_81, 0, 0, vcyc, vcnt, low, nbusy, bad);
        check("f1_dout", bus40.dout, 40'hA5C30FF081);
        check("f1_latency", vcyc, 329);
        check("f1_pulses", vcnt, 1);
        check("f1_ss_low", low, 328);
        check("f1_dout_stable", bad, 0);

        // start pulses during XFER and HOLD are ignored
        frame40(40'h01_23_45_67_89, 100, 326, vcyc, vcnt, low,
                nbusy, bad);
        check("f2_pulses", vcnt, 1);
        check("f2_latency", vcyc, 329);
        check("f2_busy_gaps", nbusy, 0);
        check("f2_dout_stable", bad, 0);
        check("f2_dout", bus40.dout, 40'h0123456789);
        check("f2_idle", bus40.busy, 0);

        // reset mid-frame, after bit 20 has been sampled
        data40 = 40'hFF_FF_FF_FF_FF;
        start40 = 1'b1;
        nv = 0;
        for (int c = 1; c <= 164; c++) begin
            tick();
            start40 = 1'b0;
            if (bus40.dout_valid) nv++;
        end
        rst40 = 1'b1;
        tick();
        check("abort_ss_n", bus40.ss_n, 1);
        check("abort_sclk", bus40.sclk, 0);
        check("abort_dout", bus40.dout, 0);
        check("abort_busy", bus40.busy, 0);
        tick();
        if (bus40.dout_valid) nv++;
        check("abort_no_valid", nv, 0);
        rst40 = 1'b0;
        tick();
        frame40(40'hA5_C3_0F_F0_81, 0, 0, vcyc, vcnt, low, nbusy, bad);
        check("f3_dout", bus40.dout, 40'hA5C30FF081);
        check("f3_latency", vcyc, 329);

        // mode sweep, 8-bit frames
        for (int m = 0; m < 4; m++) begin
            logic pol;
            int e0;
            pol = (m >= 2);
            check("mode_idle_sclk", sclk8[m], pol);
            data8[m] = 8'h3C;
            e0 = edges8[m];
            lat = 0;
            start8[m] = 1'b1;
            for (int c = 1; c <= 120 && lat == 0; c++) begin
                tick();
                start8[m] = 1'b0;
                if (valid8[m]) lat = c;
            end
            check("mode_latency", lat, 73);
            check("mode_dout", dout8[m], 8'h3C);
            check("mode_edges", edges8[m] - e0, 16);
            tick();
            check("mode_sclk_after", sclk8[m], pol);
        end

        // continuous framing on mode 0
        nv = 0; hi = 0; ng = 0;
        data8[0] = 8'h11;
        cont8[0] = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (valid8[0] && nv < 4) begin
                got[nv] = dout8[0];
                nv++;
                data8[0] = (nv == 1) ? 8'h22 : 8'h33;
            end
            if (ss8[0]) begin
                hi++;
            end else begin
                if (hi > 0 && nv > 0 && ng < 2) begin
                    gaps[ng] = hi;
                    ng++;
                end
                hi = 0;
                if (nv == 2) cont8[0] = 1'b0;
            end
        end
        check("cont_frames", nv, 3);
        check("cont_d0", got[0], 8'h11);
        check("cont_d1", got[1], 8'h22);
        check("cont_d2", got[2], 8'h33);
        check("cont_gap0", gaps[0], 5);
        check("cont_gap1", gaps[1], 5);
        check("cont_idle", busy8[0], 0);

        // minimum divider, single-bit frame
        check("min_rst_dout", bus1.dout, 0);
        data1 = 1'b1;
        start1 = 1'b1;
        lat = 0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            tick();
            start1 = 1'b0;
            if (bus1.dout_valid) lat = c;
        end
        check("min_latency", lat, 9);
        check("min_dout", bus1.dout, 1);
        tick();
        check("min_valid_pulse", bus1.dout_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
